// File: rtl/recip_table_writer_if.sv
// Write-side bus of the reciprocal table generator: build request/status
// plus the single-entry table write port.
interface recip_table_writer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;

    // Generator side: takes the build request, drives status and writes.
    modport master (
        input  start,
        output busy,
        output done,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // Requester / table-storage side.
    modport slave (
        output start,
        input  busy,
        input  done,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/recip_table_writer.sv
// Builds the reciprocal table: entry k = min(floor(NUMER/(k+1)), 255) for
// k = 0..ENTRIES-1, one bit-serial restoring division per entry, each result
// written through a single-entry write port. All outputs are registered.
module recip_table_writer #(
    parameter int unsigned ENTRIES = 12,
    parameter int unsigned NUMER   = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    recip_table_writer_if.master bus
);
    localparam logic [8:0] NUM    = 9'(NUMER);
    localparam logic [3:0] LAST_K = 4'(ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        WRITE
    } state_t;

    state_t      state;
    logic [3:0]  k;
    logic [3:0]  cnt;
    logic [4:0]  rem;
    // Only the low 8 quotient bits are kept between steps; the 9th bit
    // appears on the final shift and is consumed directly from quo_nxt.
    logic [7:0]  quo;

    logic        busy_r;
    logic        done_r;
    logic        wr_en_r;
    logic [3:0]  wr_addr_r;
    logic [15:0] wr_data_r;

    logic [4:0]  divisor;
    logic        n_bit;
    logic [5:0]  rem_sh;
    logic        take;
    logic [4:0]  rem_nxt;
    logic [8:0]  quo_nxt;
    logic [7:0]  q_sat;

    // One restoring-division step: shift in the next numerator bit (MSB
    // first), subtract the divisor when it fits, and saturate the result.
    always_comb begin
        divisor = {1'b0, k} + 5'd1;
        n_bit   = NUM[4'd8 - cnt];
        rem_sh  = {rem, n_bit};
        take    = (rem_sh >= {1'b0, divisor});
        rem_nxt = take ? 5'(rem_sh - {1'b0, divisor}) : rem_sh[4:0];
        quo_nxt = {quo, take};
        q_sat   = quo_nxt[8] ? 8'hFF : quo_nxt[7:0];
    end

    // Build sequencer: IDLE -> (DIV x9 -> WRITE) per entry -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= DIV;
                        k      <= '0;
                        cnt    <= '0;
                        rem    <= '0;
                        quo    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt[7:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        state     <= WRITE;
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= k;
                        wr_data_r <= {8'h00, q_sat};
                    end
                end
                WRITE: begin
                    wr_en_r <= 1'b0;
                    if (k == LAST_K) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        state <= DIV;
                        k     <= k + 4'd1;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
endmodule

// File: tb/tb_recip_table_writer.sv
// Scoreboard bench for recip_table_writer: stimulus pushes the expected
// writes (address, data, edge index) and done pulses; a negedge monitor pops
// and compares whenever the DUT presents wr_en or done.
module tb_recip_table_writer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    recip_table_writer_if bus();

    recip_table_writer #(
        .ENTRIES(12),
        .NUMER  (256)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    wr_t wq[$];
    int  dq[$];

    // Count rising edges; at a negedge, cyc equals the index of the last edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer division with saturation to 8 bits.
    function automatic int ref_recip(input int k);
        int q;
        q = 256 / (k + 1);
        return (q > 255) ? 255 : q;
    endfunction

    function automatic void push_build(input int e0, input int n_written, input bit with_done);
        for (int k = 0; k < n_written; k++)
            wq.push_back('{addr: k, data: ref_recip(k), at: e0 + 10 * k + 9});
        if (with_done) dq.push_back(e0 + 120);
    endfunction

    function automatic void check_zero(input string tag);
        check({tag, "_busy"},    bus.busy,    0);
        check({tag, "_done"},    bus.done,    0);
        check({tag, "_wr_en"},   bus.wr_en,   0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
    endfunction

    // Monitor: compare every presented write / done against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                if (wq.size() == 0) begin
                    check("unexpected_wr_en", bus.wr_en, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", bus.wr_addr, e.addr);
                    check("wr_data", bus.wr_data, e.data);
                    check("wr_cycle", cyc, e.at);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    int at;
                    at = dq.pop_front();
                    check("done_cycle", cyc, at);
                end
            end
        end
    end

    // One build from IDLE; abort_at>0 resets 2ns after edge E(abort_at).
    task automatic run_build(input int abort_at, input bit pulses);
        int e0;
        int nw;
        int idx;
        bit pulse_at[0:130];
        foreach (pulse_at[i]) pulse_at[i] = 1'b0;
        if (pulses) begin
            pulse_at[5]   = 1'b1;
            pulse_at[59]  = 1'b1;
            pulse_at[120] = 1'b1;
            repeat (3) begin
                idx = int'($urandom_range(120, 1));
                pulse_at[idx] = 1'b1;
            end
        end
        @(negedge clk);
        bus.start = 1'b1;
        e0 = cyc + 1;
        if (abort_at > 0) begin
            nw = 0;
            for (int k = 0; k < 12; k++)
                if (10 * k + 9 < abort_at) nw++;
            push_build(e0, nw, 1'b0);
        end else begin
            push_build(e0, 12, 1'b1);
        end
        for (int off = 0; off <= 124; off++) begin
            @(negedge clk);
            if (abort_at > 0 && off == abort_at - 1) begin
                bus.start = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 check_zero("abort");
                check("abort_pending_writes", wq.size(), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("busy", bus.busy, (off < 120) ? 1 : 0);
            bus.start = pulses ? pulse_at[off + 1] : 1'b0;
        end
        bus.start = 1'b0;
    endtask

    // start held high: second build must begin at E121 after the first E0.
    task automatic run_b2b();
        int e0;
        @(negedge clk);
        bus.start = 1'b1;
        e0 = cyc + 1;
        push_build(e0, 12, 1'b1);
        push_build(e0 + 121, 12, 1'b1);
        for (int off = 0; off <= 245; off++) begin
            @(negedge clk);
            if (off == 120) check("b2b_busy_gap", bus.busy, 0);
            if (off == 121) check("b2b_busy_restart", bus.busy, 1);
            if (off == 130) bus.start = 1'b0;
        end
    endtask

    initial begin
        int gap;
        int r;
        bus.start = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_wr_en", bus.wr_en, 0);
        end

        run_build(0, 1'b1);
        run_build(45, 1'b0);
        run_build(0, 1'b0);

        for (int it = 0; it < 4; it++) begin
            gap = int'($urandom_range(6, 0));
            repeat (gap) @(negedge clk);
            if ($urandom_range(1, 0) == 1) begin
                do r = int'($urandom_range(119, 1)); while (r % 10 == 9);
                run_build(r, 1'b0);
            end else begin
                run_build(0, 1'b1);
            end
        end

        run_b2b();

        repeat (5) @(negedge clk);
        check("pending_writes", wq.size(), 0);
        check("pending_done", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
